// File: rtl/fan_timer_value_ctrl.sv
// Fan/timer value controller: owns the countdown, converts seconds to BCD with a
// sequential shift-add-3 engine and drives fan/timer display digits. Option: DONE_BLINK_EN.
module fan_timer_value_ctrl #(
    parameter int FAN_LEVELS  = 4,
    parameter int FAN_W       = 2,
    parameter int PRESET_STEP = 5,
    parameter int NUM_PRESETS = 3,
    parameter int SEL_W       = 2,
    parameter int CNT_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_tick,
    input  logic [FAN_W-1:0] i_fanState,
    input  logic [SEL_W-1:0] i_timerSel,
    input  logic             i_start,
    input  logic             i_cancel,
    output logic [3:0]       o_1000_value,
    output logic [3:0]       o_100_value,
    output logic [3:0]       o_10_value,
    output logic [3:0]       o_1_value,
    output logic             o_FANOnOff,
    output logic             o_TIMEROnOff,
    output logic             o_done
);

    localparam int SR_W = 12 + CNT_W;
    localparam int IT_W = $clog2(CNT_W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [SEL_W-1:0] clampSel(input logic [SEL_W-1:0] sel);
        if (32'(sel) > NUM_PRESETS) return SEL_W'(NUM_PRESETS);
        return sel;
    endfunction

    function automatic logic [FAN_W-1:0] clampFan(input logic [FAN_W-1:0] lvl);
        if (32'(lvl) > FAN_LEVELS - 1) return FAN_W'(FAN_LEVELS - 1);
        return lvl;
    endfunction

    function automatic logic over999(input logic [CNT_W-1:0] v);
        return 32'(v) > 32'd999;
    endfunction

    function automatic logic [SR_W-1:0] bcdStep(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int d = 0; d < 3; d++) begin
            if (t[CNT_W + 4*d +: 4] >= 4'd5) t[CNT_W + 4*d +: 4] = t[CNT_W + 4*d +: 4] + 4'd3;
        end
        return t << 1;
    endfunction

    state_t             state, stateNext;
    logic [SEL_W-1:0]   selClamped_p0;
    logic [CNT_W-1:0]   preset_p0;
    logic [FAN_W-1:0]   fanLevel_p0;
    logic [FAN_W-1:0]   fanPrev_p1;
    logic [CNT_W-1:0]   r_remain, remainNext;
    logic               r_fanKill, fanKillNext;
    logic               startOk, doneEntry, fanChanged;

    logic               convBusy, convSat;
    logic [IT_W-1:0]    bitCnt;
    logic [SR_W-1:0]    convSr, convStep_p1;
    logic [3:0]         hundQ, tensQ, onesQ;

`ifdef DONE_BLINK_EN
    logic [1:0]         blinkCnt;
    logic               blank;
`endif

    // Stage p0: input clamping and next-state decode
    always_comb begin
        selClamped_p0 = clampSel(i_timerSel);
        preset_p0     = CNT_W'(32'(selClamped_p0) * PRESET_STEP);
        fanLevel_p0   = clampFan(i_fanState);
        fanChanged    = (i_fanState != fanPrev_p1);
    end

    always_comb begin
        stateNext  = state;
        remainNext = r_remain;
        startOk    = 1'b0;
        doneEntry  = 1'b0;
        case (state)
            IDLE: begin
                remainNext = preset_p0;
                if (i_start && selClamped_p0 != '0) begin
                    startOk   = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                // cancel outranks a same-cycle tick
                if (i_cancel) begin
                    stateNext = IDLE;
                end else if (i_tick) begin
                    if (r_remain <= CNT_W'(1)) begin
                        remainNext = '0;
                        stateNext  = DONE;
                        doneEntry  = 1'b1;
                    end else begin
                        remainNext = r_remain - CNT_W'(1);
                    end
                end
            end
            DONE: begin
`ifdef DONE_BLINK_EN
                if (i_cancel) begin
                    stateNext = IDLE;
                end else if (i_start && selClamped_p0 != '0) begin
                    startOk    = 1'b1;
                    stateNext  = RUN;
                    remainNext = preset_p0;
                end else if (i_tick && blinkCnt == 2'd2) begin
                    stateNext = IDLE;
                end
`else
                stateNext = IDLE;
`endif
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        fanKillNext = r_fanKill;
        if (fanChanged || startOk) fanKillNext = 1'b0;
        if (doneEntry) fanKillNext = 1'b1;
    end

    // Stage p1: control and fan output registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            r_remain     <= '0;
            r_fanKill    <= 1'b0;
            fanPrev_p1   <= '0;
            o_1000_value <= 4'd0;
            o_FANOnOff   <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            state        <= stateNext;
            r_remain     <= remainNext;
            r_fanKill    <= fanKillNext;
            fanPrev_p1   <= i_fanState;
            o_1000_value <= 4'(fanLevel_p0);
            o_FANOnOff   <= (fanLevel_p0 != '0) && !fanKillNext;
            o_done       <= doneEntry;
        end
    end

`ifdef DONE_BLINK_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            blinkCnt <= 2'd0;
            blank    <= 1'b0;
        end else if (doneEntry) begin
            blinkCnt <= 2'd0;
            blank    <= 1'b0;
        end else if (state == DONE && i_tick && !i_cancel && !startOk) begin
            blinkCnt <= blinkCnt + 2'd1;
            blank    <= ~blank;
        end
    end
`endif

    assign o_TIMEROnOff = (state == RUN);
    assign convStep_p1  = bcdStep(convSr);

    // Converter: snapshot when idle, CNT_W iterations, atomic publish on the last one
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            convBusy <= 1'b0;
            convSat  <= 1'b0;
            convSr   <= '0;
            bitCnt   <= '0;
            hundQ    <= 4'd0;
            tensQ    <= 4'd0;
            onesQ    <= 4'd0;
        end else if (!convBusy) begin
            convSr   <= {12'd0, r_remain};
            convSat  <= over999(r_remain);
            bitCnt   <= '0;
            convBusy <= 1'b1;
        end else begin
            convSr <= convStep_p1;
            bitCnt <= bitCnt + IT_W'(1);
            if (bitCnt == IT_W'(CNT_W - 1)) begin
                convBusy <= 1'b0;
                if (convSat) begin
                    hundQ <= 4'd9;
                    tensQ <= 4'd9;
                    onesQ <= 4'd9;
                end else begin
                    hundQ <= convStep_p1[SR_W-1 -: 4];
                    tensQ <= convStep_p1[SR_W-5 -: 4];
                    onesQ <= convStep_p1[SR_W-9 -: 4];
                end
            end
        end
    end

    always_comb begin
        o_100_value = hundQ;
        o_10_value  = tensQ;
        o_1_value   = onesQ;
`ifdef DONE_BLINK_EN
        if (state == DONE) begin
            o_100_value = blank ? 4'hF : 4'h0;
            o_10_value  = blank ? 4'hF : 4'h0;
            o_1_value   = blank ? 4'hF : 4'h0;
        end
`endif
    end

endmodule

// File: tb/tb_fan_timer_value_ctrl.sv
// Directed bench for fan_timer_value_ctrl: default instance plus a clamp-parameter instance,
// expected values queued at stimulus time and popped at each observation.
module tb_fan_timer_value_ctrl;

    logic       clk = 1'b0;
    logic       rst, tick, start, cancel;
    logic [1:0] fan, sel;

    logic [3:0] a1000, a100, a10, a1;
    logic       aFan, aTimer, aDone;
    logic [3:0] c1000, c100, c10, c1;
    logic       cFan, cTimer, cDone;

    int checks = 0;
    int errors = 0;
    int doneSeenA = 0;
    int d0;

    typedef struct {
        string      tag;
        logic [11:0] val;
    } exp_t;
    exp_t expQ[$];

    fan_timer_value_ctrl dut (
        .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_fanState(fan), .i_timerSel(sel),
        .i_start(start), .i_cancel(cancel),
        .o_1000_value(a1000), .o_100_value(a100), .o_10_value(a10), .o_1_value(a1),
        .o_FANOnOff(aFan), .o_TIMEROnOff(aTimer), .o_done(aDone)
    );

    fan_timer_value_ctrl #(.FAN_LEVELS(3), .NUM_PRESETS(2)) dutC (
        .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_fanState(fan), .i_timerSel(sel),
        .i_start(start), .i_cancel(cancel),
        .o_1000_value(c1000), .o_100_value(c100), .o_10_value(c10), .o_1_value(c1),
        .o_FANOnOff(cFan), .o_TIMEROnOff(cTimer), .o_done(cDone)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (aDone) doneSeenA++;

    function automatic logic [11:0] bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic logic [11:0] digA();
        return {a100, a10, a1};
    endfunction

    function automatic logic [11:0] digC();
        return {c100, c10, c1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expectVal(input string tag, input logic [11:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        expQ.push_back(e);
    endtask

    task automatic checkObs(input logic [11:0] obs);
        exp_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
            return;
        end
        e = expQ.pop_front();
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic waitDig(input bit useC, input int bound);
        logic [11:0] cur;
        for (int i = 0; i < bound; i++) begin
            cur = useC ? digC() : digA();
            if (expQ.size() != 0 && cur === expQ[0].val) break;
            step();
        end
        checkObs(useC ? digC() : digA());
    endtask

    task automatic pulseStart();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic tickAndSettle();
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (33) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; tick = 1'b0; start = 1'b0; cancel = 1'b0; fan = 2'd0; sel = 2'd0;
        repeat (3) step();
        expectVal("rst_fan_digit", 12'd0); checkObs(12'(a1000));
        expectVal("rst_fan_on",    12'd0); checkObs(12'(aFan));
        expectVal("rst_timer_on",  12'd0); checkObs(12'(aTimer));
        expectVal("rst_done",      12'd0); checkObs(12'(aDone));
        expectVal("rst_digits",    bcd(0)); checkObs(digA());

        // Reset release and preview
        rst = 1'b0; fan = 2'd2; sel = 2'd2;
        step();
        expectVal("preview_fan_digit", 12'd2); checkObs(12'(a1000));
        expectVal("preview_fan_on",    12'd1); checkObs(12'(aFan));
        expectVal("preview_digits",    bcd(10)); waitDig(1'b0, 19);
        expectVal("preview_timer_off", 12'd0); checkObs(12'(aTimer));

        // Full countdown from preset 1
        sel = 2'd1;
        expectVal("cd_preview", bcd(5)); waitDig(1'b0, 20);
        d0 = doneSeenA;
        pulseStart();
        expectVal("cd_timer_on", 12'd1); checkObs(12'(aTimer));
        for (int k = 1; k <= 4; k++) begin
            tickAndSettle();
            expectVal($sformatf("cd_digit_%0d", 5 - k), bcd(5 - k)); checkObs(digA());
        end
        sel = 2'd0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        expectVal("cd_done_pulse", 12'd1); checkObs(12'(aDone));
        expectVal("cd_fan_killed", 12'd0); checkObs(12'(aFan));
        expectVal("cd_timer_off",  12'd0); checkObs(12'(aTimer));
        step();
        expectVal("cd_done_single", 12'd0); checkObs(12'(aDone));
        expectVal("cd_final_digits", bcd(0)); waitDig(1'b0, 20);
        repeat (30) step();
        expectVal("cd_done_count", 12'd1); checkObs(12'(doneSeenA - d0));

        // Fan kill hold and release
        repeat (5) step();
        expectVal("kill_hold", 12'd0); checkObs(12'(aFan));
        fan = 2'd3;
        step();
        expectVal("kill_release",   12'd1); checkObs(12'(aFan));
        expectVal("kill_fan_digit", 12'd3); checkObs(12'(a1000));

        // Cancel against a same-cycle tick
        sel = 2'd3;
        expectVal("cxl_preview", bcd(15)); waitDig(1'b0, 20);
        d0 = doneSeenA;
        pulseStart();
        for (int k = 1; k <= 4; k++) tickAndSettle();
        expectVal("cxl_remain_11", bcd(11)); checkObs(digA());
        cancel = 1'b1; tick = 1'b1;
        step();
        cancel = 1'b0; tick = 1'b0;
        expectVal("cxl_timer_off", 12'd0); checkObs(12'(aTimer));
        expectVal("cxl_back_preview", bcd(15)); waitDig(1'b0, 20);
        repeat (5) step();
        expectVal("cxl_no_done", 12'd0); checkObs(12'(doneSeenA - d0));

        // Clamp instance: NUM_PRESETS=2, FAN_LEVELS=3
        expectVal("clamp_sel_preview", bcd(10)); waitDig(1'b1, 20);
        expectVal("clamp_fan_digit",   12'd2); checkObs(12'(c1000));
        expectVal("clamp_fan_on",      12'd1); checkObs(12'(cFan));

        // Start with selection 0 is ignored
        sel = 2'd0;
        expectVal("sel0_preview", bcd(0)); waitDig(1'b0, 20);
        d0 = doneSeenA;
        pulseStart();
        expectVal("sel0_timer_off", 12'd0); checkObs(12'(aTimer));
        expectVal("sel0_timer_offC", 12'd0); checkObs(12'(cTimer));
        tickAndSettle();
        expectVal("sel0_still_idle", 12'd0); checkObs(12'(aTimer));
        expectVal("sel0_no_done", 12'd0); checkObs(12'(doneSeenA - d0));

        // Asynchronous reset mid-run
        sel = 2'd2;
        expectVal("mid_preview", bcd(10)); waitDig(1'b0, 20);
        pulseStart();
        for (int k = 1; k <= 3; k++) tickAndSettle();
        expectVal("mid_remain_7", bcd(7)); checkObs(digA());
        d0 = doneSeenA;
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        expectVal("mid_rst_digits",   bcd(0)); checkObs(digA());
        expectVal("mid_rst_fan_digit", 12'd0); checkObs(12'(a1000));
        expectVal("mid_rst_fan_on",   12'd0); checkObs(12'(aFan));
        expectVal("mid_rst_timer",    12'd0); checkObs(12'(aTimer));
        expectVal("mid_rst_done",     12'd0); checkObs(12'(aDone));
        expectVal("mid_rst_doneC",    12'd0); checkObs(12'(cDone));
        step();
        rst = 1'b0;
        step();
        expectVal("mid_after_timer", 12'd0); checkObs(12'(aTimer));
        expectVal("mid_after_preview", bcd(10)); waitDig(1'b0, 20);
        tickAndSettle();
        tickAndSettle();
        expectVal("mid_after_no_done", 12'd0); checkObs(12'(doneSeenA - d0));
        expectVal("mid_after_idle", 12'd0); checkObs(12'(aTimer));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
